// File: rtl/satsub_pipe_if.sv
// rtl/satsub_pipe_if.sv - operand/result handshake bundle for satsub_pipe
interface satsub_pipe_if #(
   parameter int W     = 12,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     y;
   logic             sat;
   logic [CNT_W-1:0] sat_cnt;
   logic             cnt_clr;

   modport master (
      output in_valid, a, b, mode, out_ready, cnt_clr,
      input  in_ready, out_valid, y, sat, sat_cnt
   );

   modport slave (
      input  in_valid, a, b, mode, out_ready, cnt_clr,
      output in_ready, out_valid, y, sat, sat_cnt
   );
endinterface

// File: rtl/satsub_pipe.sv
// rtl/satsub_pipe.sv - two-stage pipelined saturating subtractor with sticky saturation counter
module satsub_pipe #(
   parameter int W     = 12,
   parameter int CNT_W = 8
) (
   input logic         clk,
   input logic         rst_n,
   satsub_pipe_if.slave bus
);
   logic             en;
   logic [W:0]       diffFull;
   logic             ovf;

   logic [W-1:0]     s1Diff;
   logic             s1Borrow;
   logic             s1Ovf;
   logic             s1Sign;
   logic [1:0]       s1Mode;
   logic             s1Valid;

   logic [W-1:0]     satY;
   logic             satBit;
   logic [W-1:0]     yReg;
   logic             satReg;
   logic             outValidReg;
   logic [CNT_W-1:0] satCnt;
   logic             deliverSat;

   // Whole pipe advances together; a stalled output freezes both stages.
   assign en           = !outValidReg || bus.out_ready;
   assign bus.in_ready = en;

   assign diffFull = {1'b0, bus.a} - {1'b0, bus.b};
   assign ovf      = (bus.a[W-1] != bus.b[W-1]) && (diffFull[W-1] != bus.a[W-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Diff   <= '0;
         s1Borrow <= 1'b0;
         s1Ovf    <= 1'b0;
         s1Sign   <= 1'b0;
         s1Mode   <= 2'b00;
         s1Valid  <= 1'b0;
      end else if (en) begin
         s1Diff   <= diffFull[W-1:0];
         s1Borrow <= diffFull[W];
         s1Ovf    <= ovf;
         s1Sign   <= bus.a[W-1];
         s1Mode   <= bus.mode;
         s1Valid  <= bus.in_valid;
      end
   end

   always_comb begin
      satY   = s1Diff;
      satBit = 1'b0;
      case (s1Mode)
         2'b00: begin
            if (s1Borrow) begin
               satY   = '0;
               satBit = 1'b1;
            end
         end
         2'b01: begin
            if (s1Ovf) begin
               // Negative minuend overflows toward the most negative value.
               satY   = s1Sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
               satBit = 1'b1;
            end
         end
         default: begin
            satY   = s1Diff;
            satBit = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yReg        <= '0;
         satReg      <= 1'b0;
         outValidReg <= 1'b0;
      end else if (en) begin
         yReg        <= satY;
         satReg      <= satBit;
         outValidReg <= s1Valid;
      end
   end

   assign deliverSat = outValidReg && bus.out_ready && satReg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         satCnt <= '0;
      end else if (bus.cnt_clr) begin
         satCnt <= '0;
      end else if (deliverSat && (satCnt != {CNT_W{1'b1}})) begin
         satCnt <= satCnt + 1'b1;
      end
   end

   assign bus.y         = yReg;
   assign bus.sat       = satReg;
   assign bus.out_valid = outValidReg;
   assign bus.sat_cnt   = satCnt;
endmodule
